mode_seq_ctrl: RTL and testbench
================================

// Module: mode_seq_ctrl
// PURPOSE
//  Top-level sequencer for the shared 4-digit display and the keypad. Decodes debounced
//  keycodes into one-shot commands, owns the STOPWATCH/CALC mode, drives the stopwatch
//  run/stop/clear command, and multiplexes the stopwatch count or calculator answer into
//  a multi-cycle binary-to-BCD converter that refreshes the digit registers.
// PARAMETERS
//  VAL_W   32  width of stopwatch count (tenths of s) and calculator answer
//  DIGITS  4   BCD digits driven; clamp limit is 10**DIGITS-1
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        async active-low reset
//  key_code       in   4        keypad code, valid while key_valid=1
//  key_valid      in   1        level, high for as long as a key is held
//  sw_count       in   VAL_W    live stopwatch count, tenths of a second
//  calc_answer    in   VAL_W    calculator magnitude
//  calc_negative  in   1        calculator result is negative
//  sw_cmd         out  2        stopwatch command: 0 stop, 1 run, 2 clear
//  mode           out  1        0 stopwatch, 1 calculator
//  digits         out  4*DIGITS digit codes, [3:0]=least significant; 0-9 digit, 10 '-', 11 blank
//  disp_valid     out  1        1-cycle pulse when digits update
//  busy           out  1        converter active
// BEHAVIOUR
//  Reset (async, rst_n=0): sw_cmd=0, mode=0, sw state IDLE, lap_reg=0, digits all 0,
//   disp_valid=0, busy=0, converter CV_IDLE, key edge register cleared.
//  Key accept: one action per press, taken on the cycle with key_valid=1 and registered
//   key_valid=0. A held key does nothing further. A new code without release is ignored.
//  Mode FSM (acts on accepted keys):
//   SW:   14 or 15 -> CALC (key consumed; stopwatch state and sw_cmd untouched).
//   CALC: 13 -> SW (consumed; NOT a stop). All other keys are ignored here.
//  Stopwatch FSM (SW mode only); sw_cmd is registered, so it changes 1 cycle after accept:
//   IDLE  (cmd 0, display lap_reg): 12 -> RUN; 10 -> CLEAR.
//   RUN   (cmd 1, display sw_count): 11 -> LAP with lap_reg<=sw_count; 13 -> IDLE with
//         lap_reg<=sw_count; 10 -> CLEAR.
//   LAP   (cmd 1, display lap_reg): 12 -> RUN; 11 re-latches lap_reg; 13 -> IDLE; 10 -> CLEAR.
//   CLEAR (cmd 2 for exactly 1 cycle, lap_reg<=0) -> IDLE.
//  Converter: source = display value of the stopwatch state (SW) or calc_answer (CALC).
//   CV_IDLE: start whenever idle. Sample the source and clamp it to 10**DIGITS-1.
//   In CALC with calc_negative=1, use |answer| mod 100.
//   CV_SHIFT: shift-add-3 double dabble, 1 bit/cycle, VAL_W cycles, busy=1.
//   CV_DONE: write digits atomically, pulse disp_valid, -> CV_IDLE.
//   Sample-to-digits latency = VAL_W+2 cycles. Digits refresh continuously.
//   Negative format: [blank, '-', tens, ones]. Positive values are zero-padded.
//  Mode change during CV_SHIFT: abort with no digit update. Restart on the next cycle
//   using the new source.
//  Input change mid-conversion: ignored. The sampled value is completed first.
//  Key accept and converter DONE in the same cycle: both take effect. The digits show
//   the previously sampled source.
//  Arithmetic: no % or / operators. All BCD comes from the shifter. Clamp compare at VAL_W bits.
// TESTING
//  Reset, then 12, sw_count=1234, wait VAL_W+3 -> sw_cmd=1, digits=1,2,3,4, disp_valid pulsed.
//  RUN, press 11 at sw_count=57, then sw_count ramps to 90 -> digits hold 0,0,5,7; 12 -> tracks 90.
//  Hold key 10 for 20 cycles -> sw_cmd=2 for exactly 1 cycle, then 0; digits go to 0,0,0,0.
//  Press 14, calc_answer=42, calc_negative=1 -> mode=1, digits=11,10,4,2; 13 -> mode=0, sw_cmd unchanged.
//  calc_answer=123456 positive -> digits 9,9,9,9. Mode toggles mid-shift -> no disp_valid for the
//   aborted run; the next pulse carries the new source.
//  rst_n low mid-CV_SHIFT with mode=1 -> all outputs at reset values that cycle; no disp_valid after release.

Source files
------------

// File: rtl/mode_seq_ctrl.sv
// mode_seq_ctrl
//   Top-level sequencer for the shared 4-digit display and the keypad.
//   Key presses become one-shot commands. The block owns the STOPWATCH/CALC
//   mode, drives the stopwatch run/stop/clear command, and feeds either the
//   stopwatch value or the calculator answer into a bit-serial binary-to-BCD
//   converter that keeps refreshing the digit registers.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   key_code        keypad code, valid while key_valid=1
//   key_valid       level, high for as long as a key is held
//   sw_count        live stopwatch count (tenths of a second)
//   calc_answer     calculator magnitude
//   calc_negative   calculator result is negative
//   sw_cmd          stopwatch command: 0 stop, 1 run, 2 clear
//   mode            0 stopwatch, 1 calculator
//   digits          4-bit digit codes, [3:0] least significant;
//                   0-9 digit, 10 '-', 11 blank
//   disp_valid      one-cycle pulse when digits update
//   busy            converter is shifting
//
// Handshake: key_valid is a level. A key is acted on exactly once, on the
// first cycle it is seen high after having been low. There is no back-pressure.
module mode_seq_ctrl #(
  parameter int VAL_W  = 32,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            key_code,
  input  logic                  key_valid,
  input  logic [VAL_W-1:0]      sw_count,
  input  logic [VAL_W-1:0]      calc_answer,
  input  logic                  calc_negative,
  output logic [1:0]            sw_cmd,
  output logic                  mode,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  disp_valid,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [VAL_W-1:0] CLAMP = VAL_W'(10 ** DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(VAL_W - 1);

  localparam logic [3:0] K_CLEAR = 4'd10;
  localparam logic [3:0] K_LAP   = 4'd11;
  localparam logic [3:0] K_RUN   = 4'd12;
  localparam logic [3:0] K_STOP  = 4'd13;  // also returns CALC -> SW
  localparam logic [3:0] K_CALCA = 4'd14;
  localparam logic [3:0] K_CALCB = 4'd15;

  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_LAP, SW_CLEAR} sw_state_t;
  typedef enum logic [1:0] {CV_IDLE, CV_SHIFT, CV_DONE} cv_state_t;

  sw_state_t          sw_state, sw_next;
  cv_state_t          cv_state;
  logic               key_prev;
  logic               accept;
  logic               mode_next;
  logic               sw_key;
  logic [VAL_W-1:0]   lap_reg, lap_next;
  logic [1:0]         sw_cmd_next;
  logic [VAL_W-1:0]   src_val, load_val;
  logic               neg_src, neg_reg;
  logic [VAL_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg, bcd_adj, neg_digits;
  logic [CNT_W-1:0]   bit_cnt;

  assign accept = key_valid & ~key_prev;

  // Mode switching keys are consumed here and never reach the stopwatch.
  always_comb begin
    mode_next = mode;
    sw_key    = 1'b0;
    if (accept) begin
      if (!mode) begin
        if (key_code == K_CALCA || key_code == K_CALCB) mode_next = 1'b1;
        else                                            sw_key    = 1'b1;
      end else if (key_code == K_STOP) begin
        mode_next = 1'b0;
      end
    end
  end

  always_comb begin
    sw_next  = sw_state;
    lap_next = lap_reg;
    case (sw_state)
      SW_IDLE: begin
        if (sw_key && key_code == K_RUN)        sw_next = SW_RUN;
        else if (sw_key && key_code == K_CLEAR) sw_next = SW_CLEAR;
      end
      SW_RUN: begin
        if (sw_key && key_code == K_LAP) begin
          sw_next  = SW_LAP;
          lap_next = sw_count;
        end else if (sw_key && key_code == K_STOP) begin
          sw_next  = SW_IDLE;
          lap_next = sw_count;
        end else if (sw_key && key_code == K_CLEAR) begin
          sw_next = SW_CLEAR;
        end
      end
      SW_LAP: begin
        if (sw_key && key_code == K_RUN)        sw_next  = SW_RUN;
        else if (sw_key && key_code == K_LAP)   lap_next = sw_count;
        else if (sw_key && key_code == K_STOP)  sw_next  = SW_IDLE;
        else if (sw_key && key_code == K_CLEAR) sw_next  = SW_CLEAR;
      end
      default: begin
        sw_next  = SW_IDLE;
        lap_next = '0;
      end
    endcase
    if (sw_next == SW_CLEAR) lap_next = '0;
  end

  // Command is registered from the next state so it tracks the stopwatch
  // state one cycle after the accepting edge.
  always_comb begin
    case (sw_next)
      SW_RUN, SW_LAP: sw_cmd_next = 2'd1;
      SW_CLEAR:       sw_cmd_next = 2'd2;
      default:        sw_cmd_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev <= 1'b0;
      mode     <= 1'b0;
      sw_state <= SW_IDLE;
      lap_reg  <= '0;
      sw_cmd   <= 2'd0;
    end else begin
      key_prev <= key_valid;
      mode     <= mode_next;
      sw_state <= sw_next;
      lap_reg  <= lap_next;
      sw_cmd   <= sw_cmd_next;
    end
  end

  // Converter source selection. A negative answer is converted unclamped:
  // the low BCD digits of a truncated double-dabble register are exactly
  // value mod 10**DIGITS, so the two lowest digits give |answer| mod 100.
  always_comb begin
    src_val  = (sw_state == SW_RUN) ? sw_count : lap_reg;
    if (mode) src_val = calc_answer;
    neg_src  = mode & calc_negative;
    load_val = src_val;
    if (!neg_src && src_val > CLAMP) load_val = CLAMP;
  end

  always_comb begin
    bcd_adj = bcd_reg;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_reg[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_reg[4*d +: 4] + 4'd3;
    end
  end

  // Negative layout: blanks above, '-' in the third digit, then tens, ones.
  always_comb begin
    neg_digits = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (d < 2)       neg_digits[4*d +: 4] = bcd_reg[4*d +: 4];
      else if (d == 2) neg_digits[4*d +: 4] = 4'd10;
      else             neg_digits[4*d +: 4] = 4'd11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv_state   <= CV_IDLE;
      bin_reg    <= '0;
      bcd_reg    <= '0;
      bit_cnt    <= '0;
      neg_reg    <= 1'b0;
      digits     <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      case (cv_state)
        CV_IDLE: begin
          bin_reg  <= load_val;
          bcd_reg  <= '0;
          bit_cnt  <= '0;
          neg_reg  <= neg_src;
          cv_state <= CV_SHIFT;
        end
        CV_SHIFT: begin
          // A mode change invalidates the sampled source: drop it silently.
          if (mode_next != mode) begin
            cv_state <= CV_IDLE;
          end else begin
            {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) cv_state <= CV_DONE;
          end
        end
        default: begin
          digits     <= neg_reg ? neg_digits : bcd_reg;
          disp_valid <= 1'b1;
          cv_state   <= CV_IDLE;
        end
      endcase
    end
  end

  assign busy = (cv_state == CV_SHIFT);

endmodule

// File: tb/tb_mode_seq_ctrl.sv
// Directed bench for mode_seq_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge or 1ns after the rising edge.
module tb_mode_seq_ctrl;

  localparam int VAL_W  = 32;
  localparam int DIGITS = 4;
  localparam int LAT    = VAL_W + 2;
  localparam int SETTLE = 80;

  logic                clk;
  logic                rst_n;
  logic [3:0]          key_code;
  logic                key_valid;
  logic [VAL_W-1:0]    sw_count;
  logic [VAL_W-1:0]    calc_answer;
  logic                calc_negative;
  logic [1:0]          sw_cmd;
  logic                mode;
  logic [4*DIGITS-1:0] digits;
  logic                disp_valid;
  logic                busy;

  int checks = 0;
  int errors = 0;

  mode_seq_ctrl #(.VAL_W(VAL_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .sw_count(sw_count), .calc_answer(calc_answer), .calc_negative(calc_negative),
    .sw_cmd(sw_cmd), .mode(mode), .digits(digits), .disp_valid(disp_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One press: key high across exactly one rising edge, then released.
  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_code  = code;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Counts rising edges until disp_valid is seen; 0 means timeout.
  task automatic wait_pulse(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (disp_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      errors++;
      $display("FAIL wait_pulse: no disp_valid within 100 cycles");
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; key_valid = 1'b0; key_code = '0;
    sw_count = '0; calc_answer = '0; calc_negative = 1'b0;
    wait_cycles(3);
    checks++;
    if ({sw_cmd, mode, digits, disp_valid, busy} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%0d mode=%0d digits=%h dv=%0d busy=%0d want all 0",
               sw_cmd, mode, digits, disp_valid, busy);
    end
    rst_n = 1'b1;
    wait_pulse(n);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL first_latency: got %0d edges want %0d", n, LAT);
    end
    checks++;
    if (digits !== 16'h0000) begin
      errors++;
      $display("FAIL first_digits: got %h want 0000", digits);
    end
  endtask

  task automatic test_run();
    sw_count = 1234;
    @(negedge clk);
    key_code = 4'd12; key_valid = 1'b1;
    checks++;
    if (sw_cmd !== 2'd0) begin
      errors++;
      $display("FAIL cmd_before_accept: got %0d want 0", sw_cmd);
    end
    @(negedge clk);
    key_valid = 1'b0;
    checks++;
    if (sw_cmd !== 2'd1) begin
      errors++;
      $display("FAIL run_cmd: got %0d want 1", sw_cmd);
    end
    wait_cycles(SETTLE);
    checks++;
    if (digits !== 16'h1234) begin
      errors++;
      $display("FAIL run_digits: got %h want 1234", digits);
    end
  endtask

  task automatic test_lap();
    sw_count = 57;
    press(4'd11);
    for (int v = 58; v <= 90; v++) begin
      sw_count = v;
      @(negedge clk);
    end
    wait_cycles(SETTLE);
    checks++;
    if (digits !== 16'h0057 || sw_cmd !== 2'd1) begin
      errors++;
      $display("FAIL lap_hold: got digits=%h cmd=%0d want 0057 cmd=1", digits, sw_cmd);
    end
    press(4'd12);
    wait_cycles(SETTLE);
    checks++;
    if (digits !== 16'h0090) begin
      errors++;
      $display("FAIL lap_resume: got %h want 0090", digits);
    end
  endtask

  task automatic test_clear_held();
    int n2;
    n2 = 0;
    @(negedge clk);
    key_code = 4'd10; key_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 19) key_valid = 1'b0;
      if (sw_cmd == 2'd2) n2++;
    end
    checks++;
    if (n2 !== 1) begin
      errors++;
      $display("FAIL clear_pulse_len: got %0d cycles want 1", n2);
    end
    checks++;
    if (sw_cmd !== 2'd0) begin
      errors++;
      $display("FAIL clear_after: got %0d want 0", sw_cmd);
    end
    wait_cycles(SETTLE);
    checks++;
    if (digits !== 16'h0000) begin
      errors++;
      $display("FAIL clear_digits: got %h want 0000", digits);
    end
  endtask

  // A code change without a release must not produce a second action.
  task automatic test_code_change_held();
    int n2;
    n2 = 0;
    @(negedge clk);
    key_code = 4'd12; key_valid = 1'b1;
    wait_cycles(2);
    key_code = 4'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sw_cmd == 2'd2) n2++;
    end
    key_valid = 1'b0;
    checks++;
    if (n2 !== 0 || sw_cmd !== 2'd1) begin
      errors++;
      $display("FAIL held_code_change: got clear_cycles=%0d cmd=%0d want 0 and 1", n2, sw_cmd);
    end
  endtask

  task automatic test_calc();
    calc_answer = 42; calc_negative = 1'b1;
    press(4'd14);
    checks++;
    if (mode !== 1'b1 || sw_cmd !== 2'd1) begin
      errors++;
      $display("FAIL enter_calc: got mode=%0d cmd=%0d want 1 1", mode, sw_cmd);
    end
    wait_cycles(SETTLE);
    checks++;
    if (digits !== 16'hBA42) begin
      errors++;
      $display("FAIL calc_neg_digits: got %h want ba42", digits);
    end
    press(4'd10);
    checks++;
    if (mode !== 1'b1 || sw_cmd !== 2'd1) begin
      errors++;
      $display("FAIL calc_ignores_key: got mode=%0d cmd=%0d want 1 1", mode, sw_cmd);
    end
    press(4'd13);
    checks++;
    if (mode !== 1'b0 || sw_cmd !== 2'd1) begin
      errors++;
      $display("FAIL leave_calc: got mode=%0d cmd=%0d want 0 1", mode, sw_cmd);
    end
  endtask

  task automatic test_clamp();
    press(4'd15);
    calc_negative = 1'b0; calc_answer = 123456;
    wait_cycles(SETTLE);
    checks++;
    if (digits !== 16'h9999) begin
      errors++;
      $display("FAIL clamp_high: got %h want 9999", digits);
    end
    calc_answer = 9998;
    wait_cycles(SETTLE);
    checks++;
    if (digits !== 16'h9998) begin
      errors++;
      $display("FAIL clamp_below: got %h want 9998", digits);
    end
    calc_negative = 1'b1; calc_answer = 123456;
    wait_cycles(SETTLE);
    checks++;
    if (digits !== 16'hBA56) begin
      errors++;
      $display("FAIL neg_mod100: got %h want ba56", digits);
    end
  endtask

  // Leave CALC mid-shift: the pending 0777 conversion must be dropped.
  task automatic test_mode_abort();
    int n;
    calc_negative = 1'b0; calc_answer = 777;
    wait_cycles(SETTLE);
    wait_pulse(n);
    wait_cycles(5);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_shift: got %0d want 1", busy);
    end
    press(4'd13);
    wait_pulse(n);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL abort_latency: got %0d edges want %0d", n, LAT);
    end
    checks++;
    if (digits !== 16'h0090) begin
      errors++;
      $display("FAIL abort_new_src: got %h want 0090", digits);
    end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    int stray;
    press(4'd14);
    wait_pulse(n);
    wait_cycles(10);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_cmd, mode, digits, disp_valid, busy} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid_shift: got cmd=%0d mode=%0d digits=%h dv=%0d busy=%0d want all 0",
               sw_cmd, mode, digits, disp_valid, busy);
    end
    wait_cycles(2);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < LAT - 1; i++) begin
      @(posedge clk);
      #1;
      if (disp_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL no_stale_pulse: got %0d pulses want 0", stray);
    end
    wait_pulse(n);
    checks++;
    if (digits !== 16'h0000 || mode !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_digits: got digits=%h mode=%0d want 0000 0", digits, mode);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_lap();
    test_clear_held();
    test_code_change_held();
    test_calc();
    test_clamp();
    test_mode_abort();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
